// File: rtl/pmc_gen_if.sv
// Command/sensor/drive bundle of the proportional motion controller.
// master = command side, slave = pmc_gen.
interface pmc_gen_if #(
  parameter int W = 4
);
  logic         en;
  logic         estop;
  logic [W-1:0] speed_i;
  logic [W-1:0] dir_i;
  logic [1:0]   mode;
  logic         f1;
  logic         f2;
  logic         b1;
  logic         b2;
  logic [W-1:0] speed_o;
  logic [W-1:0] dir_o;
  logic         upd;
  logic         at_target;

  modport master (
    output en, estop, speed_i, dir_i, mode, f1, f2, b1, b2,
    input  speed_o, dir_o, upd, at_target
  );

  modport slave (
    input  en, estop, speed_i, dir_i, mode, f1, f2, b1, b2,
    output speed_o, dir_o, upd, at_target
  );
endinterface

// File: rtl/pmc_gen.sv
// Proportional motion controller: debounced proximity sensors select a per-mode
// ramp action; speed/direction step toward their targets at a prescaled rate.
module pmc_gen #(
  parameter int W             = 4,
  parameter int STEP          = 1,
  parameter int DEFAULT_SPEED = 5,
  parameter int DEFAULT_DIR   = 8,
  parameter int RATE_DIV      = 1,
  parameter int DEB_CYCLES    = 2
) (
  input logic       clk,
  input logic       rst,
  pmc_gen_if.slave  bus
);
  localparam int PW = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam logic [W:0]          STEP_X = STEP[W:0];
  localparam logic [W:0]          MAX_X  = {1'b0, {W{1'b1}}};
  localparam logic signed [W+1:0] STEP_S = {1'b0, STEP_X};
  localparam logic [W-1:0]        DS     = DEFAULT_SPEED[W-1:0];
  localparam logic [W-1:0]        DD     = DEFAULT_DIR[W-1:0];

  typedef enum logic [1:0] {OP_UP, OP_DN, OP_TRK} op_t;

  function automatic logic [W-1:0] step_up(input logic [W-1:0] v);
    logic [W:0] s;
    s = {1'b0, v} + STEP_X;
    return (s > MAX_X) ? MAX_X[W-1:0] : s[W-1:0];
  endfunction

  function automatic logic [W-1:0] step_down(input logic [W-1:0] v);
    return ({1'b0, v} < STEP_X) ? '0 : v - STEP_X[W-1:0];
  endfunction

  function automatic logic [W-1:0] step_trk(input logic [W-1:0] v, input logic [W-1:0] t);
    logic signed [W+1:0] diff;
    diff = $signed({2'b00, t}) - $signed({2'b00, v});
    if (diff > STEP_S)
      return step_up(v);
    else if (diff < -STEP_S)
      return step_down(v);
    else
      return t;
  endfunction

  function automatic logic [W-1:0] apply_op(input op_t op, input logic [W-1:0] v,
                                           input logic [W-1:0] t);
    case (op)
      OP_UP:   return step_up(v);
      OP_DN:   return step_down(v);
      default: return step_trk(v, t);
    endcase
  endfunction

  logic [3:0]    raw;
  logic [3:0]    raw_p0;
  logic [3:0]    sens_s;
  logic [DW-1:0] deb_cnt;
  logic [DW-1:0] deb_nxt;
  logic [PW-1:0] pres;
  logic          tick;
  logic [W-1:0]  spd_q, dir_q, sp_t, dr_t, sp_nxt, dr_nxt, spd_dn;
  logic          upd_q, at_q;
  op_t           sp_op, dr_op;

  assign raw = {bus.f1, bus.f2, bus.b1, bus.b2};

  // Stage p0: raw sensor sample and run-length of identical samples
  always_comb begin
    deb_nxt = deb_cnt;
    if (raw != raw_p0)
      deb_nxt = DW'(1);
    else if (deb_cnt != DW'(DEB_CYCLES))
      deb_nxt = deb_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      raw_p0  <= '0;
      deb_cnt <= '0;
      sens_s  <= '0;
    end else begin
      raw_p0  <= raw;
      deb_cnt <= deb_nxt;
      if (deb_nxt == DW'(DEB_CYCLES))
        sens_s <= raw;
    end
  end

  // Action select from debounced sensors and mode, then stepped candidates
  always_comb begin
    sp_op = OP_TRK;
    dr_op = OP_TRK;
    sp_t  = DS;
    dr_t  = DD;
    case (bus.mode)
      2'd0, 2'd1: begin
        if (bus.mode == 2'd1) begin
          sp_t = bus.speed_i;
          dr_t = bus.dir_i;
        end
        case (sens_s)
          4'b1100: sp_op = OP_DN;
          4'b0011: sp_op = OP_UP;
          4'b1000: dr_op = OP_UP;
          4'b0100: dr_op = OP_DN;
          4'b1011: begin sp_op = OP_UP; dr_op = OP_UP; end
          4'b0111: begin sp_op = OP_UP; dr_op = OP_DN; end
          default: ;
        endcase
      end
      2'd2: begin
        sp_t = bus.speed_i;
        dr_t = bus.dir_i;
      end
      default: begin
        case (sens_s)
          4'b1100: sp_op = OP_DN;
          4'b0011: ;
          4'b1000: dr_op = OP_UP;
          4'b0100: begin sp_op = OP_DN; dr_op = OP_DN; end
          4'b1011: dr_op = OP_UP;
          4'b0111: dr_op = OP_DN;
          default: sp_op = OP_DN;
        endcase
      end
    endcase
    sp_nxt = apply_op(sp_op, spd_q, sp_t);
    dr_nxt = apply_op(dr_op, dir_q, dr_t);
  end

  assign tick   = bus.en && !bus.estop && (pres == PW'(RATE_DIV - 1));
  assign spd_dn = step_down(spd_q);

  // Output register: estop ramp-down overrides the prescaled update
  always_ff @(posedge clk) begin
    if (rst) begin
      pres  <= '0;
      spd_q <= '0;
      dir_q <= '0;
      upd_q <= 1'b0;
      at_q  <= 1'b0;
    end else if (bus.estop) begin
      spd_q <= spd_dn;
      upd_q <= (spd_q != '0);
      at_q  <= (spd_dn == '0);
    end else if (bus.en) begin
      pres  <= tick ? '0 : pres + 1'b1;
      upd_q <= tick;
      if (tick) begin
        spd_q <= sp_nxt;
        dir_q <= dr_nxt;
        at_q  <= (sp_nxt == spd_q) && (dr_nxt == dir_q);
      end
    end else begin
      upd_q <= 1'b0;
    end
  end

  assign bus.speed_o   = spd_q;
  assign bus.dir_o     = dir_q;
  assign bus.upd       = upd_q;
  assign bus.at_target = at_q;
endmodule
